memory_stage_controller: RTL and testbench
==========================================

Name: memory_stage_controller

Overview:
Sequences the data-memory access of the memory stage over a req/ready/rvalid handshake to a variable-latency data memory. Stalls the front of the pipeline until the access completes. Captures returned load data for the MEM/WB pipeline register and forces a bubble into that register while the access is outstanding. A timeout guard keeps a dead memory from hanging the core.

Parameters:
DATA_WIDTH, 32, data word width
ADDRESS_BITS, 20, data-memory word address width
TIMEOUT_CYCLES, 255, maximum cycles in REQUEST+WAIT_RESP before abort (≥2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
load_memory  input  1  memory-stage instruction is a load
store_memory  input  1  memory-stage instruction is a store
address_memory  input  ADDRESS_BITS  access address from the ALU result
store_data_memory  input  DATA_WIDTH  store data
dmem_req  output  1  request valid to data memory
dmem_we  output  1  1=write, 0=read, valid with dmem_req
dmem_addr  output  ADDRESS_BITS  latched access address
dmem_wdata  output  DATA_WIDTH  latched store data
dmem_ready  input  1  memory accepts the request this cycle
dmem_rvalid  input  1  read data valid
dmem_rdata  input  DATA_WIDTH  read data
load_data_memory  output  DATA_WIDTH  load result toward MEM/WB register
stall_memory  output  1  hold PC and the IF/ID, ID/EX, EX/MEM registers
bubble_writeback  output  1  force opwrite=0 into the MEM/WB register
timeout_error  output  1  sticky abort flag
stall_cycles  output  32  saturating count of cycles with stall_memory=1

Behaviour:
- Reset is synchronous, active-high, on clock. While reset=1, outputs are:
  - FSM=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
  - load_data_memory=0, timeout_error=0, stall_cycles=0
  - stall_memory=0, bubble_writeback=1 (both forced)
- FSM states are IDLE, REQUEST, WAIT_RESP and RESPOND.
- IDLE:
  - If load_memory or store_memory: latch address, data and we=store&~load, then go to REQUEST. stall_memory=1 combinationally this cycle.
  - Load and store both high: treated as a load.
  - No memory op: stall_memory=0, bubble_writeback=0, load_data_memory holds its last value.
- REQUEST:
  - dmem_req=1 with addr/wdata/we stable until dmem_ready=1. The request is never withdrawn.
  - On ready: a store goes to RESPOND, a load goes to WAIT_RESP.
- WAIT_RESP:
  - dmem_rvalid is sampled only in this state. rvalid in the same cycle as the ready acceptance is ignored.
  - On rvalid: capture dmem_rdata into load_data_memory, go to RESPOND.
- RESPOND:
  - stall_memory=0, bubble_writeback=0 for exactly one cycle.
  - The pipeline advances at this clock edge. Next state is IDLE.
- stall_memory=1 in REQUEST and WAIT_RESP, and in IDLE when an op is present.
- bubble_writeback equals stall_memory except during reset and the timeout RESPOND.
- Minimum load latency is 3 stall cycles (IDLE, REQUEST with ready=1, WAIT_RESP with rvalid=1). The RESPOND cycle follows unstalled. Minimum store latency is 2 stall cycles.
- Timeout:
  - Counter is cleared on entering REQUEST and increments every cycle in REQUEST/WAIT_RESP.
  - When it equals TIMEOUT_CYCLES-1 without completion:
    - set timeout_error (sticky until reset)
    - drop dmem_req
    - load_data_memory=0
    - go to RESPOND with bubble_writeback=1, so no register write occurs
  - Completion wins over timeout in the same cycle.
- Reset mid-access returns to IDLE with dmem_req=0 on the following cycle. A late dmem_rvalid seen in IDLE or REQUEST is ignored.
- stall_cycles saturates at 0xFFFF_FFFF.

Decomposition:
- Shared package (memory_pkg): state encoding localparams (IDLE=2'd0, REQUEST=2'd1, WAIT_RESP=2'd2, RESPOND=2'd3) and a TIMEOUT_WIDTH=$clog2(TIMEOUT_CYCLES+1) helper constant.
- One natural sub-module: mem_timeout_counter (clear, enable, expired output), reusable by the instruction-fetch controller.

Test Plan:
1. Load at 0x00040, ready=1 on first REQUEST cycle, rvalid=1 with rdata=0xDEADBEEF one cycle later → stall high 3 cycles, then RESPOND with load_data_memory=0xDEADBEEF, bubble=0, stall_cycles=3.
2. Store to 0x00100 of 0x12345678, ready held low 4 cycles then high → dmem_req/addr/wdata/we=1 stable throughout, RESPOND on the cycle after ready, no rvalid needed.
3. Load with rvalid asserted in the same cycle as ready, and again 2 cycles later with 0xA5A5A5A5 → first ignored, load_data_memory=0xA5A5A5A5.
4. TIMEOUT_CYCLES=8, load with ready never asserted → after 8 cycles dmem_req drops, timeout_error=1, RESPOND with bubble_writeback=1, load_data_memory=0; flag persists through later accesses.
5. Reset asserted in WAIT_RESP, then rvalid=1 → FSM IDLE, dmem_req=0 next cycle, rvalid ignored, stall_memory=0 with no op present.
6. Back-to-back load then non-memory op → second instruction sees stall_memory=0 and bubble_writeback=0 in the cycle after RESPOND.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared definitions for the memory-stage access controllers: state encoding and
// timeout-counter sizing.
package memory_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQUEST   = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] RESPOND   = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = IDLE,
    StRequest  = REQUEST,
    StWaitResp = WAIT_RESP,
    StRespond  = RESPOND
  } mem_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Counter width able to hold any value up to and including the timeout limit.
  function automatic int unsigned timeout_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned TIMEOUT_WIDTH = timeout_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter that flags expiry on the TimeoutCycles-th enabled cycle after a clear.
// Shared by the memory-stage and instruction-fetch access controllers.
module mem_timeout_counter
  import memory_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned Width = timeout_width(TimeoutCycles);
  localparam logic [Width-1:0] Limit = Width'(TimeoutCycles - 1);

  logic [Width-1:0] count_q, count_d;

  // Holds at the limit so a late enable can never wrap back into range.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != Limit)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == Limit);

endmodule

// File: rtl/memory_stage_controller.sv
// Memory-stage data access sequencer: drives the req/ready/rvalid handshake, stalls the
// front of the pipeline while an access is outstanding and bubbles the MEM/WB register.
module memory_stage_controller
  import memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_BITS   = 20,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_memory,
  input  logic                    store_memory,
  input  logic [ADDRESS_BITS-1:0] address_memory,
  input  logic [DATA_WIDTH-1:0]   store_data_memory,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDRESS_BITS-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic                    dmem_ready,
  input  logic                    dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic [DATA_WIDTH-1:0]   load_data_memory,
  output logic                    stall_memory,
  output logic                    bubble_writeback,
  output logic                    timeout_error,
  output logic [31:0]             stall_cycles
);

  mem_state_e state_q, state_d;

  logic                    we_q, we_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
  logic                    timeout_error_q, timeout_error_d;
  logic                    abort_q, abort_d;
  logic [31:0]             stall_cycles_q, stall_cycles_d;

  logic mem_op;
  logic expired;
  logic timeout_abort;

  assign mem_op = load_memory | store_memory;

  mem_timeout_counter #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  ((state_q == StIdle) && mem_op),
    .enable_i ((state_q == StRequest) || (state_q == StWaitResp)),
    .expired_o(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A store is complete on acceptance; a load only on rvalid. Completion beats expiry.
  always_comb begin
    state_d       = state_q;
    timeout_abort = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_op) state_d = StRequest;
      end
      StRequest: begin
        if (dmem_ready && we_q) begin
          state_d = StRespond;
        end else if (expired) begin
          timeout_abort = 1'b1;
          state_d       = StRespond;
        end else if (dmem_ready) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (dmem_rvalid) begin
          state_d = StRespond;
        end else if (expired) begin
          timeout_abort = 1'b1;
          state_d       = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    dmem_req         = 1'b0;
    stall_memory     = 1'b0;
    bubble_writeback = 1'b0;
    if (reset) begin
      bubble_writeback = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          stall_memory     = mem_op;
          bubble_writeback = mem_op;
        end
        StRequest: begin
          dmem_req         = 1'b1;
          stall_memory     = 1'b1;
          bubble_writeback = 1'b1;
        end
        StWaitResp: begin
          stall_memory     = 1'b1;
          bubble_writeback = 1'b1;
        end
        StRespond: bubble_writeback = abort_q;
        default:   bubble_writeback = 1'b1;
      endcase
    end
  end

  // Load-and-store together is resolved as a load.
  always_comb begin
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    load_data_d     = load_data_q;
    timeout_error_d = timeout_error_q | timeout_abort;
    abort_d         = timeout_abort;
    if ((state_q == StIdle) && mem_op) begin
      we_d    = store_memory & ~load_memory;
      addr_d  = address_memory;
      wdata_d = store_data_memory;
    end
    if ((state_q == StWaitResp) && dmem_rvalid) begin
      load_data_d = dmem_rdata;
    end else if (timeout_abort) begin
      load_data_d = '0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_memory && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      load_data_q     <= '0;
      timeout_error_q <= 1'b0;
      abort_q         <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      load_data_q     <= load_data_d;
      timeout_error_q <= timeout_error_d;
      abort_q         <= abort_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign load_data_memory = load_data_q;
  assign timeout_error    = timeout_error_q;
  assign stall_cycles     = stall_cycles_q;

endmodule

// File: tb/tb_memory_stage_controller.sv
// Directed bench for memory_stage_controller with an 8-cycle timeout.
module tb_memory_stage_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_memory, store_memory;
  logic [19:0] address_memory;
  logic [31:0] store_data_memory;
  logic        dmem_req, dmem_we;
  logic [19:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data_memory;
  logic        stall_memory, bubble_writeback, timeout_error;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  memory_stage_controller #(
    .DATA_WIDTH    (32),
    .ADDRESS_BITS  (20),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .load_memory      (load_memory),
    .store_memory     (store_memory),
    .address_memory   (address_memory),
    .store_data_memory(store_data_memory),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ready       (dmem_ready),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .load_data_memory (load_data_memory),
    .stall_memory     (stall_memory),
    .bubble_writeback (bubble_writeback),
    .timeout_error    (timeout_error),
    .stall_cycles     (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; load_memory = 1'b0; store_memory = 1'b0;
    address_memory = '0; store_data_memory = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    load_memory = 1'b1;
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", {12'd0, dmem_addr}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_load_data", load_data_memory, 32'd0);
    chk("rst_timeout", {31'd0, timeout_error}, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_stall_forced", {31'd0, stall_memory}, 32'd0);
    chk("rst_bubble_forced", {31'd0, bubble_writeback}, 32'd1);

    reset = 1'b0; load_memory = 1'b0;
    #1;
    chk("idle_noop_stall", {31'd0, stall_memory}, 32'd0);
    chk("idle_noop_bubble", {31'd0, bubble_writeback}, 32'd0);
    tick();

    // Test 1: minimum-latency load
    load_memory = 1'b1; address_memory = 20'h00040;
    #1;
    chk("t1_idle_stall", {31'd0, stall_memory}, 32'd1);
    chk("t1_idle_bubble", {31'd0, bubble_writeback}, 32'd1);
    chk("t1_idle_req", {31'd0, dmem_req}, 32'd0);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("t1_req", {31'd0, dmem_req}, 32'd1);
    chk("t1_addr", {12'd0, dmem_addr}, 32'h00040);
    chk("t1_we", {31'd0, dmem_we}, 32'd0);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_wait_stall", {31'd0, stall_memory}, 32'd1);
    chk("t1_wait_req", {31'd0, dmem_req}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("t1_resp_stall", {31'd0, stall_memory}, 32'd0);
    chk("t1_resp_bubble", {31'd0, bubble_writeback}, 32'd0);
    chk("t1_resp_data", load_data_memory, 32'hDEADBEEF);
    chk("t1_stall_cycles", stall_cycles, 32'd3);

    // Test 6: non-memory op right after RESPOND
    load_memory = 1'b0;
    tick();
    chk("t6_stall", {31'd0, stall_memory}, 32'd0);
    chk("t6_bubble", {31'd0, bubble_writeback}, 32'd0);
    chk("t6_data_hold", load_data_memory, 32'hDEADBEEF);

    // Test 2: store with ready held low for 4 cycles
    store_memory = 1'b1; address_memory = 20'h00100; store_data_memory = 32'h12345678;
    #1;
    chk("t2_idle_stall", {31'd0, stall_memory}, 32'd1);
    tick();
    address_memory = 20'h0FFFF; store_data_memory = 32'h0;
    for (int i = 0; i < 5; i++) begin
      dmem_ready = (i == 4);
      #1;
      chk("t2_req", {31'd0, dmem_req}, 32'd1);
      chk("t2_we", {31'd0, dmem_we}, 32'd1);
      chk("t2_addr", {12'd0, dmem_addr}, 32'h00100);
      chk("t2_wdata", dmem_wdata, 32'h12345678);
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    chk("t2_resp_req", {31'd0, dmem_req}, 32'd0);
    chk("t2_resp_stall", {31'd0, stall_memory}, 32'd0);
    chk("t2_resp_bubble", {31'd0, bubble_writeback}, 32'd0);
    chk("t2_stall_cycles", stall_cycles, 32'd9);
    chk("t2_data_hold", load_data_memory, 32'hDEADBEEF);
    store_memory = 1'b0;
    tick();

    // Test 3: rvalid alongside ready is ignored; later rvalid is captured
    load_memory = 1'b1; store_memory = 1'b1; address_memory = 20'h00200;
    tick();
    dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
    #1;
    chk("t3_both_is_load", {31'd0, dmem_we}, 32'd0);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    #1;
    chk("t3_wait1_stall", {31'd0, stall_memory}, 32'd1);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    #1;
    chk("t3_wait2_stall", {31'd0, stall_memory}, 32'd1);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("t3_resp_data", load_data_memory, 32'hA5A5A5A5);
    chk("t3_resp_bubble", {31'd0, bubble_writeback}, 32'd0);
    chk("t3_stall_cycles", stall_cycles, 32'd13);
    load_memory = 1'b0; store_memory = 1'b0;
    tick();

    // Test 4: timeout with ready never asserted
    load_memory = 1'b1; address_memory = 20'h00300;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t4_req_held", {31'd0, dmem_req}, 32'd1);
      chk("t4_no_err_yet", {31'd0, timeout_error}, 32'd0);
      tick();
    end
    chk("t4_req_dropped", {31'd0, dmem_req}, 32'd0);
    chk("t4_timeout_err", {31'd0, timeout_error}, 32'd1);
    chk("t4_resp_bubble", {31'd0, bubble_writeback}, 32'd1);
    chk("t4_resp_stall", {31'd0, stall_memory}, 32'd0);
    chk("t4_resp_data", load_data_memory, 32'd0);
    chk("t4_stall_cycles", stall_cycles, 32'd22);
    load_memory = 1'b0;
    tick();
    chk("t4_idle_err_sticky", {31'd0, timeout_error}, 32'd1);
    chk("t4_idle_bubble", {31'd0, bubble_writeback}, 32'd0);

    // Minimum-latency store; error flag persists
    store_memory = 1'b1; address_memory = 20'h00500; store_data_memory = 32'h0BADF00D;
    tick();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("t4b_resp_bubble", {31'd0, bubble_writeback}, 32'd0);
    chk("t4b_err_sticky", {31'd0, timeout_error}, 32'd1);
    chk("t4b_stall_cycles", stall_cycles, 32'd24);
    store_memory = 1'b0;
    tick();

    // Test 5: reset in WAIT_RESP, late rvalid ignored
    load_memory = 1'b1; address_memory = 20'h00400;
    tick();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("t5_wait_stall", {31'd0, stall_memory}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("t5_rst_stall", {31'd0, stall_memory}, 32'd0);
    chk("t5_rst_bubble", {31'd0, bubble_writeback}, 32'd1);
    tick();
    reset = 1'b0; load_memory = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("t5_idle_req", {31'd0, dmem_req}, 32'd0);
    chk("t5_idle_stall", {31'd0, stall_memory}, 32'd0);
    chk("t5_idle_bubble", {31'd0, bubble_writeback}, 32'd0);
    chk("t5_err_cleared", {31'd0, timeout_error}, 32'd0);
    chk("t5_stall_cycles", stall_cycles, 32'd0);
    tick();
    chk("t5_rvalid_ignored", load_data_memory, 32'd0);
    chk("t5_still_idle_req", {31'd0, dmem_req}, 32'd0);
    dmem_rvalid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
